// File: rtl/dcache_pkg.sv
// Shared types, funct3 encodings and address-split width helpers for the data cache.
// Pure declarations: no latency.
// No flow control.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cacheState_t;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    function automatic int wordBits(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    function automatic int indexBits(input int numSets);
        return $clog2(numSets);
    endfunction

    function automatic int tagBits(input int addrWidth, input int numSets, input int wordsPerLine);
        return addrWidth - 2 - $clog2(numSets) - $clog2(wordsPerLine);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane steering for loads (select + extend) and stores (byte enables + replication).
// Combinational, zero latency.
// No flow control.
module load_store_align
    import dcache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] lineWord,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [3:0]  byteEn,
    output logic [31:0] storeWord
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    assign loadByte = lineWord[{byteOff, 3'b000} +: 8];
    assign loadHalf = lineWord[{byteOff[1], 4'b0000} +: 16];

    always_comb begin
        loadData = '0;
        case (funct3)
            F3_BYTE:  loadData = {{24{loadByte[7]}}, loadByte};
            F3_BYTEU: loadData = {24'b0, loadByte};
            F3_HALF:  loadData = {{16{loadHalf[15]}}, loadHalf};
            F3_HALFU: loadData = {16'b0, loadHalf};
            F3_WORD:  loadData = lineWord;
            default:  loadData = '0;
        endcase
    end

    always_comb begin
        byteEn    = 4'b0000;
        storeWord = storeData;
        case (funct3[1:0])
            2'b00: begin
                byteEn    = 4'b0001 << byteOff;
                storeWord = {4{storeData[7:0]}};
            end
            2'b01: begin
                byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
                storeWord = {2{storeData[15:0]}};
            end
            2'b10: begin
                byteEn    = 4'b1111;
                storeWord = storeData;
            end
            default: byteEn = 4'b0000;
        endcase
    end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back/write-allocate data cache with round-robin replacement.
// Hits: zero stall; clean miss W+1 stall cycles, dirty miss 2W+1.
// Stalls the pipeline via stall_o; requester holds its inputs until stall_o drops.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SETS       = 64,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_rd_i,
    input  logic                  req_wr_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    output logic                  miss_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wr_en_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

    localparam int WB  = wordBits(WORDS_PER_LINE);
    localparam int IB  = indexBits(NUM_SETS);
    localparam int TB  = tagBits(ADDR_WIDTH, NUM_SETS, WORDS_PER_LINE);
    localparam int IBW = (IB > 0) ? IB : 1;
    localparam int PW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

    logic [DATA_WIDTH-1:0] dataMem  [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
    logic [TB-1:0]         tagMem   [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]   validMem [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirtyMem [NUM_SETS];
    logic [PW-1:0]         rrPtr    [NUM_SETS];

    cacheState_t   state, stateNext;
    logic [WB-1:0] cnt, cntNext;
    logic [PW-1:0] victimWay, victimNext;

    logic [TB-1:0]  reqTag;
    logic [IBW-1:0] reqIdx;
    logic [WB-1:0]  reqWord;
    logic           reqAny;

    logic          hit, hasInvalid;
    logic [PW-1:0] hitWay, invWay, victimSel;
    logic          storeHit, refillWr, refillDone;

    logic [31:0] alignedLoad, storeWord;
    logic [3:0]  byteEn;

    assign reqTag  = addr_i[ADDR_WIDTH-1 -: TB];
    assign reqIdx  = IBW'((addr_i >> (2 + WB)) & ADDR_WIDTH'(NUM_SETS - 1));
    assign reqWord = addr_i[2 +: WB];
    assign reqAny  = req_rd_i | req_wr_i;

    function automatic logic [ADDR_WIDTH-1:0] lineAddr(input logic [TB-1:0] t,
                                                       input logic [IBW-1:0] i,
                                                       input logic [WB-1:0] w);
        return (ADDR_WIDTH'(t) << (2 + WB + IB)) | (ADDR_WIDTH'(i) << (2 + WB))
             | (ADDR_WIDTH'(w) << 2);
    endfunction

    // Descending scans leave the lowest-numbered match selected.
    always_comb begin
        hit        = 1'b0;
        hitWay     = '0;
        hasInvalid = 1'b0;
        invWay     = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (validMem[reqIdx][w] && (tagMem[w][reqIdx] == reqTag)) begin
                hit    = 1'b1;
                hitWay = PW'(w);
            end
            if (!validMem[reqIdx][w]) begin
                hasInvalid = 1'b1;
                invWay     = PW'(w);
            end
        end
    end

    assign victimSel = hasInvalid ? invWay : rrPtr[reqIdx];

    load_store_align u_align (
        .funct3    (funct3_i),
        .byteOff   (addr_i[1:0]),
        .lineWord  (dataMem[hitWay][reqIdx][reqWord]),
        .storeData (data_i),
        .loadData  (alignedLoad),
        .byteEn    (byteEn),
        .storeWord (storeWord)
    );

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        victimNext    = victimWay;
        stall_o       = 1'b0;
        miss_o        = 1'b0;
        mem_addr_o    = '0;
        mem_wr_en_o   = 1'b0;
        mem_wr_data_o = '0;
        data_o        = '0;
        storeHit      = 1'b0;
        refillWr      = 1'b0;
        refillDone    = 1'b0;
        case (state)
            IDLE: begin
                if (reqAny && hit) begin
                    if (req_wr_i) storeHit = 1'b1;
                    else          data_o   = alignedLoad;
                end else if (reqAny) begin
                    stall_o    = 1'b1;
                    miss_o     = 1'b1;
                    victimNext = victimSel;
                    cntNext    = '0;
                    stateNext  = (validMem[reqIdx][victimSel] && dirtyMem[reqIdx][victimSel])
                               ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                stall_o       = 1'b1;
                mem_wr_en_o   = 1'b1;
                mem_addr_o    = lineAddr(tagMem[victimWay][reqIdx], reqIdx, cnt);
                mem_wr_data_o = dataMem[victimWay][reqIdx][cnt];
                cntNext       = cnt + WB'(1);
                if (cnt == LAST_WORD) begin
                    stateNext = REFILL;
                    cntNext   = '0;
                end
            end
            REFILL: begin
                stall_o    = 1'b1;
                mem_addr_o = lineAddr(reqTag, reqIdx, cnt);
                refillWr   = 1'b1;
                cntNext    = cnt + WB'(1);
                if (cnt == LAST_WORD) begin
                    refillDone = 1'b1;
                    stateNext  = IDLE;
                    cntNext    = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            victimWay <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                validMem[s] <= '0;
                dirtyMem[s] <= '0;
                rrPtr[s]    <= '0;
            end
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            victimWay <= victimNext;
            if (storeHit) dirtyMem[reqIdx][hitWay] <= 1'b1;
            if (refillDone) begin
                validMem[reqIdx][victimWay] <= 1'b1;
                dirtyMem[reqIdx][victimWay] <= 1'b0;
                rrPtr[reqIdx] <= PW'((int'(rrPtr[reqIdx]) + 1) % NUM_WAYS);
            end
        end
    end

    // Line storage carries no reset; validity alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (storeHit) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteEn[b]) dataMem[hitWay][reqIdx][reqWord][8*b +: 8] <= storeWord[8*b +: 8];
                end
            end
            if (refillWr)   dataMem[victimWay][reqIdx][cnt] <= mem_rd_data_i;
            if (refillDone) tagMem[victimWay][reqIdx]       <= reqTag;
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Randomised and directed checks of dcache_assoc against a flat-memory plus tag-directory model.
module tb_dcache_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqRd = 1'b0, reqWr = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0, wrData = '0;
    logic [31:0] rdData, memAddr, memWrData, memRdData;
    logic        stall, miss, memWrEn;

    logic [31:0] mem  [4096];
    logic [31:0] gold [4096];
    bit          mValid [64][2];
    bit          mDirty [64][2];
    int          mTag   [64][2];
    int          mPtr   [64];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign memRdData = mem[memAddr[13:2]];
    always @(posedge clk) if (memWrEn) mem[memAddr[13:2]] = memWrData;

    dcache_assoc dut (
        .clk_i(clk), .rst_i(rst), .req_rd_i(reqRd), .req_wr_i(reqWr),
        .funct3_i(funct3), .addr_i(addr), .data_i(wrData), .data_o(rdData),
        .stall_o(stall), .miss_o(miss), .mem_addr_o(memAddr), .mem_wr_en_o(memWrEn),
        .mem_wr_data_o(memWrData), .mem_rd_data_i(memRdData)
    );

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w; logic [7:0] b; logic [15:0] h;
        w = gold[a[13:2]];
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 64; s++) begin
            mPtr[s] = 0;
            for (int w = 0; w < 2; w++) begin mValid[s][w] = 0; mDirty[s][w] = 0; end
        end
        for (int i = 0; i < 4096; i++) gold[i] = mem[i];
    endtask

    task automatic doReset();
        @(posedge clk); #1 rst = 1'b1; reqRd = 0; reqWr = 0;
        @(posedge clk); #1 rst = 1'b0;
        modelReset();
    endtask

    task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int s, t, hw, vw, expStall, stalls, misses, wbCnt, rfCnt;
        bit hit, wb, done;
        logic [31:0] expData, wbBase, rfBase, expA, w;
        s = int'((a >> 4) & 63); t = int'(a >> 10);
        hit = 0; hw = 0; vw = -1;
        for (int i = 1; i >= 0; i--) if (mValid[s][i] && mTag[s][i] == t) begin hit = 1; hw = i; end
        for (int i = 1; i >= 0; i--) if (!mValid[s][i]) vw = i;
        if (vw < 0) vw = mPtr[s];
        wb = !hit && mValid[s][vw] && mDirty[s][vw];
        wbBase = (32'(mTag[s][vw]) << 10) | (32'(s) << 4);
        rfBase = (32'(t) << 10) | (32'(s) << 4);
        expStall = hit ? 0 : (wb ? 9 : 5);
        expData = wr ? 32'h0 : expLoad(f3, a);
        reqRd = !wr; reqWr = wr; funct3 = f3; addr = a; wrData = d;
        stalls = 0; misses = 0; wbCnt = 0; rfCnt = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (miss) misses++;
            if (stall) begin
                stalls++;
                if (memWrEn) begin
                    expA = wbBase | (32'(wbCnt) << 2);
                    vectors++;
                    if (memAddr !== expA || memWrData !== gold[expA[13:2]]) begin
                        errors++;
                        $display("FAIL wb_word%0d addr %h data %h, want %h / %h", wbCnt, memAddr, memWrData, expA, gold[expA[13:2]]);
                    end
                    wbCnt++;
                end else if (stalls > 1) begin
                    expA = rfBase | (32'(rfCnt) << 2);
                    vectors++;
                    if (memAddr !== expA) begin
                        errors++;
                        $display("FAIL refill_addr%0d got %h want %h", rfCnt, memAddr, expA);
                    end
                    rfCnt++;
                end
            end else begin
                vectors++;
                if (rdData !== expData || memWrEn !== 1'b0) begin
                    errors++;
                    $display("FAIL hit_cycle a=%h f3=%0d data %h wren %b, want %h wren 0", a, f3, rdData, memWrEn, expData);
                end
                done = 1;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (!done || stalls != expStall || misses != (hit ? 0 : 1) || wbCnt != (wb ? 4 : 0) || rfCnt != (hit ? 0 : 4)) begin
            errors++;
            $display("FAIL timing a=%h done %0d stall %0d miss %0d wb %0d rf %0d, want stall %0d miss %0d wb %0d rf %0d",
                     a, done, stalls, misses, wbCnt, rfCnt, expStall, hit ? 0 : 1, wb ? 4 : 0, hit ? 0 : 4);
        end
        reqRd = 0; reqWr = 0;
        if (!hit) begin
            mValid[s][vw] = 1; mTag[s][vw] = t; mDirty[s][vw] = 0;
            mPtr[s] = (mPtr[s] + 1) % 2; hw = vw;
        end
        if (wr) begin
            mDirty[s][hw] = 1;
            w = gold[a[13:2]];
            case (f3[1:0])
                2'b00:   w[8*a[1:0] +: 8] = d[7:0];
                2'b01:   w[16*a[1] +: 16] = d[15:0];
                default: w = d;
            endcase
            gold[a[13:2]] = w;
        end
    endtask

    task automatic test_reset();
        doReset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (stall !== 0 || miss !== 0 || memWrEn !== 0 || memAddr !== 0 || memWrData !== 0 || rdData !== 0) begin
                errors++;
                $display("FAIL reset_idle stall %b miss %b wren %b addr %h wdata %h data %h, want all 0",
                         stall, miss, memWrEn, memAddr, memWrData, rdData);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        access(0, 3'b010, 32'h100, 0);
    endtask

    task automatic test_store_byte();
        access(1, 3'b000, 32'h101, 32'hAA);
        access(0, 3'b100, 32'h101, 0);
        access(0, 3'b000, 32'h101, 0);
    endtask

    task automatic test_dirty_evict();
        access(0, 3'b010, 32'h500, 0);
        access(0, 3'b010, 32'h900, 0);
    endtask

    task automatic test_reset_mid_miss();
        doReset();
        reqRd = 1; funct3 = 3'b010; addr = 32'h100;
        @(negedge clk);
        vectors++;
        if (miss !== 1 || stall !== 1) begin
            errors++; $display("FAIL midrst_detect miss %b stall %b, want 1 1", miss, stall);
        end
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; reqRd = 0;
        @(negedge clk);
        vectors++;
        if (stall !== 0 || memWrEn !== 0 || memAddr !== 0) begin
            errors++; $display("FAIL midrst_after stall %b wren %b addr %h, want 0 0 0", stall, memWrEn, memAddr);
        end
        @(posedge clk); #1;
        modelReset();
        access(0, 3'b010, 32'h100, 0);
    endtask

    task automatic test_halfword();
        mem[32'h40] = 32'hDEADBEEF;
        doReset();
        access(0, 3'b010, 32'h100, 0);
        access(1, 3'b001, 32'h102, 32'h8001);
        access(0, 3'b001, 32'h102, 0);
        access(0, 3'b010, 32'h100, 0);
    endtask

    task automatic test_random();
        logic [2:0] loadF3 [5];
        logic [2:0] f3;
        logic [31:0] a;
        bit wr;
        loadF3[0] = 3'b000; loadF3[1] = 3'b001; loadF3[2] = 3'b010; loadF3[3] = 3'b100; loadF3[4] = 3'b101;
        for (int i = 0; i < 150; i++) begin
            wr = ($urandom_range(0, 2) == 0);
            f3 = wr ? 3'($urandom_range(0, 2)) : loadF3[$urandom_range(0, 4)];
            a = (32'($urandom_range(0, 15)) << 10) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
            case (f3[1:0])
                2'b00:   a = a | 32'($urandom_range(0, 3));
                2'b01:   a = a | (32'($urandom_range(0, 1)) << 1);
                default: a = a;
            endcase
            access(wr, f3, a, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                vectors++;
                if (stall !== 0 || memWrEn !== 0 || memAddr !== 0) begin
                    errors++; $display("FAIL idle_gap stall %b wren %b addr %h, want 0 0 0", stall, memWrEn, memAddr);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'hC0DE0000;
        mem[32'h40] = 32'hDEADBEEF;
        test_reset();
        test_cold_miss();
        test_store_byte();
        test_dirty_evict();
        test_reset_mid_miss();
        test_halfword();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
